// File: rtl/text_pkg.sv
// Shared types and constants for the VGA text path (string renderer and plotter).
// Line wrapping is enabled by defining TEXT_WRAP_EN.
package text_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EVAL,
    ST_ISSUE,
    ST_WAIT,
    ST_ADV,
    ST_FIN
  } text_state_e;

  localparam logic [6:0] ASCII_NUL   = 7'h00;
  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_LF    = 7'h0A;

  localparam int DEF_GLYPH_W = 10;
  localparam int DEF_GLYPH_H = 14;
  localparam int DEF_GAP_X   = 5;
  localparam int DEF_GAP_Y   = 4;

  function automatic logic is_blank(input logic [6:0] c);
    return (c == ASCII_NUL) || (c == ASCII_SPACE);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Screen cursor for the string renderer: position plus column within a line.
// Wrapping after LINE_CHARS cells happens only when TEXT_WRAP_EN is defined.
module text_cursor
  import text_pkg::*;
#(
  parameter int COORD_W    = 11,
  parameter int STEP_X     = DEF_GLYPH_W + DEF_GAP_X,
  parameter int STEP_Y     = DEF_GLYPH_H + DEF_GAP_Y,
  parameter int LINE_CHARS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_advance,
  input  logic               i_newline,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y
);

  localparam int COL_W = $clog2(LINE_CHARS + 1);

`ifdef TEXT_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [COL_W-1:0]   r_col;
  logic               w_line_end;
  logic               w_break;

  assign w_line_end = WRAP_EN &&
                      (r_col == COL_W'(LINE_CHARS - 1));
  assign w_break    = i_newline ||
                      (i_advance && w_line_end);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_col <= '0;
    end else if (i_load) begin
      r_x   <= i_x0;
      r_y   <= i_y0;
      r_col <= '0;
    end else if (w_break) begin
      r_x   <= i_x0;
      r_y   <= r_y + COORD_W'(STEP_Y);
      r_col <= '0;
    end else if (i_advance) begin
      r_x   <= r_x + COORD_W'(STEP_X);
      r_col <= r_col + 1'b1;
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;

endmodule

// File: rtl/text_string_renderer.sv
// Sequences a latched ASCII string into glyph requests for the character plotter.
// Define TEXT_WRAP_EN to wrap lines and treat 0x0A as a newline.
module text_string_renderer
  import text_pkg::*;
#(
  parameter int  MAX_CHARS  = 16,
  parameter int  GLYPH_W    = DEF_GLYPH_W,
  parameter int  GLYPH_H    = DEF_GLYPH_H,
  parameter int  GAP_X      = DEF_GAP_X,
  parameter int  GAP_Y      = DEF_GAP_Y,
  parameter int  LINE_CHARS = 8,
  parameter int  COORD_W    = 11,
  localparam int LEN_W      = $clog2(MAX_CHARS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MAX_CHARS-1:0][6:0] str,
  input  logic [LEN_W-1:0]          len,
  input  logic [COORD_W-1:0]        x0,
  input  logic [COORD_W-1:0]        y0,
  output logic [6:0]                char_code,
  output logic [COORD_W-1:0]        char_x,
  output logic [COORD_W-1:0]        char_y,
  output logic                      char_valid,
  input  logic                      char_ready,
  input  logic                      char_done,
  output logic                      busy,
  output logic                      done
);

  text_state_e r_state;
  text_state_e w_next;

  logic [MAX_CHARS-1:0][6:0] r_str;
  logic [LEN_W-1:0]          r_len;
  logic [LEN_W-1:0]          r_idx;
  logic [COORD_W-1:0]        r_x0;
  logic [COORD_W-1:0]        r_y0;
  logic [6:0]                r_code;
  logic [COORD_W-1:0]        r_cx;
  logic [COORD_W-1:0]        r_cy;
  logic [6:0]                w_code;
  logic [COORD_W-1:0]        w_cur_x;
  logic [COORD_W-1:0]        w_cur_y;
  logic                      w_capture;
  logic                      w_load;
  logic                      w_adv;
  logic                      w_nl;
  logic                      w_latch;

  text_cursor #(
    .COORD_W    (COORD_W),
    .STEP_X     (GLYPH_W + GAP_X),
    .STEP_Y     (GLYPH_H + GAP_Y),
    .LINE_CHARS (LINE_CHARS)
  ) u_cursor (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_advance (w_adv),
    .i_newline (w_nl),
    .i_x0      (r_x0),
    .i_y0      (r_y0),
    .o_x       (w_cur_x),
    .o_y       (w_cur_y)
  );

  // Compare-based select keeps idx==len (one past the end) harmless.
  always_comb begin
    w_code = ASCII_NUL;
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (r_idx == LEN_W'(i)) w_code = r_str[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_load     = 1'b0;
    w_adv      = 1'b0;
    w_nl       = 1'b0;
    w_latch    = 1'b0;
    char_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_capture = 1'b1;
          w_next    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_load = 1'b1;
        w_next = ST_EVAL;
      end
      ST_EVAL: begin
        if (r_idx == r_len) begin
          w_next = ST_FIN;
        end else if (is_blank(w_code)) begin
          w_next = ST_ADV;
        end else if (w_code == ASCII_LF) begin
`ifdef TEXT_WRAP_EN
          w_nl = 1'b1;
`else
          w_next = ST_ADV;
`endif
        end else begin
          w_latch = 1'b1;
          w_next  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        char_valid = 1'b1;
        if (char_ready) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (char_done) w_next = ST_ADV;
      end
      ST_ADV: begin
        w_adv  = 1'b1;
        w_next = ST_EVAL;
      end
      ST_FIN: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_str  <= '0;
      r_len  <= '0;
      r_x0   <= '0;
      r_y0   <= '0;
      r_idx  <= '0;
      r_code <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
    end else begin
      if (w_capture) begin
        r_str <= str;
        r_len <= (len > LEN_W'(MAX_CHARS)) ?
                 LEN_W'(MAX_CHARS) : len;
        r_x0  <= x0;
        r_y0  <= y0;
      end
      if (w_load)             r_idx <= '0;
      else if (w_adv || w_nl) r_idx <= r_idx + 1'b1;
      if (w_latch) begin
        r_code <= w_code;
        r_cx   <= w_cur_x;
        r_cy   <= w_cur_y;
      end
    end
  end

  assign char_code = r_code;
  assign char_x    = r_cx;
  assign char_y    = r_cy;

endmodule

// File: tb/tb_text_string_renderer.sv
// Scoreboard bench for text_string_renderer: directed strings, plotter model,
// stall/ignored-start and mid-string reset cases. Honours TEXT_WRAP_EN.
module tb_text_string_renderer;
  import text_pkg::*;

  localparam int MC = 16;
  localparam int CW = 11;
  localparam int LW = $clog2(MC + 1);
`ifdef TEXT_WRAP_EN
  localparam int LC   = 2;
  localparam bit WRAP = 1'b1;
`else
  localparam int LC   = 8;
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic char_ready = 1'b1;
  logic plot_done = 1'b0;
  logic poke_done = 1'b0;
  logic [MC-1:0][6:0] str = '0;
  logic [LW-1:0] len = '0;
  logic [CW-1:0] x0 = '0;
  logic [CW-1:0] y0 = '0;
  logic [6:0] char_code;
  logic [CW-1:0] char_x;
  logic [CW-1:0] char_y;
  logic char_valid;
  logic busy;
  logic done;

  int cyc = 0;
  int c0 = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          is_done;
    logic [6:0]  code;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    int          rel;
  } exp_t;
  exp_t q[$];

  text_string_renderer #(
    .MAX_CHARS  (MC),
    .LINE_CHARS (LC),
    .COORD_W    (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .str        (str),
    .len        (len),
    .x0         (x0),
    .y0         (y0),
    .char_code  (char_code),
    .char_x     (char_x),
    .char_y     (char_y),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_done  (plot_done | poke_done),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void push_req(input int c, input int x,
                                   input int y, input int rel);
    exp_t e;
    e.is_done = 1'b0;
    e.code = 7'(c);
    e.x = CW'(x);
    e.y = CW'(y);
    e.rel = rel;
    q.push_back(e);
  endfunction

  function automatic void push_done(input int rel);
    exp_t e;
    e.is_done = 1'b1;
    e.code = '0;
    e.x = '0;
    e.y = '0;
    e.rel = rel;
    q.push_back(e);
  endfunction

  task automatic check(input bit d);
    exp_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL %s: unexpected event rel=%0d code=%h",
               d ? "done" : "req", cyc - c0, char_code);
    end else begin
      e = q.pop_front();
      if (e.is_done != d || (cyc - c0) != e.rel ||
          (d && busy !== 1'b1) ||
          (!d && (char_code !== e.code || char_x !== e.x ||
                  char_y !== e.y))) begin
        n_err++;
        $display("FAIL %s: got code=%h x=%0d y=%0d rel=%0d, want %s code=%h x=%0d y=%0d rel=%0d",
                 d ? "done" : "req", char_code, char_x, char_y,
                 cyc - c0, e.is_done ? "done" : "req", e.code,
                 e.x, e.y, e.rel);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every accepted request and done pulse.
  initial forever begin
    @(negedge clk);
    if (char_valid && char_ready) check(1'b0);
    if (done) check(1'b1);
  end

  // Plotter model: char_done pulses 4 cycles after acceptance.
  initial forever begin
    @(negedge clk);
    if (char_valid && char_ready) begin
      repeat (4) @(posedge clk);
      #1 plot_done = 1'b1;
      @(posedge clk);
      #1 plot_done = 1'b0;
    end
  end

  task automatic kick(input string s, input int n,
                      input int x, input int y);
    @(posedge clk);
    #1;
    str = '0;
    for (int i = 0; i < s.len() && i < MC; i++) begin
      byte b;
      b = s[i];
      str[i] = b[6:0];
    end
    len = LW'(n);
    x0 = CW'(x);
    y0 = CW'(y);
    start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    str = '1;
    x0 = CW'(777);
    y0 = CW'(555);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " pending"}, q.size(), 0);
    repeat (8) @(negedge clk);
    chk({nm, " idle"}, busy, 0);
  endtask

  initial begin
    #2;
    chk("rst valid", char_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst code", char_code, 0);
    chk("rst x", char_x, 0);
    chk("rst y", char_y, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    push_req(8'h48, 100, 50, 3);
    push_req(8'h49, 115, 50, 10);
    push_done(17);
    kick("HI", 2, 100, 50);
    chk("busy rise", busy, 1);
    chk("no early valid", char_valid, 0);
    drain("HI");

    push_req(8'h41, 0, 0, 3);
    push_req(8'h42, WRAP ? 0 : 30, WRAP ? 18 : 0, 12);
    push_done(19);
    kick("A B", 3, 0, 0);
    drain("A_B");

    push_req(8'h41, 0, 0, 3);
    push_req(8'h42, 15, 0, 10);
    push_req(8'h43, WRAP ? 0 : 30, WRAP ? 18 : 0, 17);
    push_done(24);
    kick("ABC", 3, 0, 0);
    drain("ABC");

    push_req(8'h41, 0, 0, 3);
    push_req(8'h42, WRAP ? 0 : 30, WRAP ? 18 : 0,
             WRAP ? 11 : 12);
    push_done(WRAP ? 18 : 19);
    kick("A\nB", 3, 0, 0);
    drain("LF");

    push_done(3);
    kick("XY", 0, 5, 5);
    drain("len0");

    for (int i = 0; i < MC; i++)
      push_req(65 + i, WRAP ? (i % LC) * 15 : i * 15,
               WRAP ? (i / LC) * 18 : 0, 3 + 7 * i);
    push_done(115);
    kick("ABCDEFGHIJKLMNOP", 20, 0, 0);
    drain("clamp");

    char_ready = 1'b0;
    push_req(8'h5A, 7, 9, 13);
    push_done(20);
    kick("Z", 1, 7, 9);
    do @(negedge clk); while (cyc - c0 < 3);
    for (int r = 3; r <= 12; r++) begin
      chk("stall valid", char_valid, 1);
      chk("stall code", char_code, 7'h5A);
      chk("stall x", char_x, 7);
      chk("stall y", char_y, 9);
      if (r == 6) begin
        start = 1'b1;
        len = LW'(3);
        x0 = CW'(300);
      end
      if (r == 7) start = 1'b0;
      if (r == 8) poke_done = 1'b1;
      if (r == 9) poke_done = 1'b0;
      if (r < 12) begin
        @(negedge clk);
      end else begin
        @(posedge clk);
        #1 char_ready = 1'b1;
        poke_done = 1'b1;
        @(posedge clk);
        #1 poke_done = 1'b0;
      end
    end
    drain("stall");

    push_req(8'h48, 100, 50, 3);
    kick("HI", 2, 100, 50);
    do @(negedge clk); while (cyc - c0 < 5);
    #2 reset = 1'b1;
    #1;
    chk("arst valid", char_valid, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst code", char_code, 0);
    chk("arst x", char_x, 0);
    chk("arst y", char_y, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("arst pending", q.size(), 0);
    chk("arst idle", busy, 0);

    push_req(8'h4F, 1, 2, 3);
    push_req(8'h4B, 16, 2, 10);
    push_done(17);
    kick("OK", 2, 1, 2);
    drain("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/text_string_renderer.md
# text_string_renderer

Parametrised string sequencer for the VGA text path. It takes a latched ASCII string of up to `MAX_CHARS` characters and hands one glyph request at a time to the downstream character plotter over a valid/ready/done handshake. It advances a screen cursor with configurable glyph pitch and skips blanks without issuing requests. Optionally it wraps onto new lines. It sits between the game/UI control FSMs and the character plotter that drives the frame-buffer writer.

## Interface
- `MAX_CHARS`, 16: string capacity in characters.
- `GLYPH_W`, 10: glyph cell width in pixels.
- `GLYPH_H`, 14: glyph cell height in pixels.
- `GAP_X`, 5: horizontal gap between glyphs.
- `GAP_Y`, 4: vertical gap between lines.
- `LINE_CHARS`, 8: characters per line before wrap.
- `COORD_W`, 11: coordinate width.

- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: begin rendering; sampled only in IDLE.
- `str`  in  7 x `MAX_CHARS`: ASCII codes; `str[0]` is rendered first.
- `len`  in  $clog2(`MAX_CHARS`+1): number of characters to render.
- `x0`, `y0`  in  `COORD_W`: origin (top-left) of the first glyph.
- `char_code`  out  7: glyph to draw.
- `char_x`, `char_y`  out  `COORD_W`: glyph origin.
- `char_valid`  out  1: request valid.
- `char_ready`  in  1: plotter accepts request.
- `char_done`  in  1: plotter finished the current glyph (1-cycle pulse).
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: 1-cycle pulse when the string completes.

## Operation
- States: IDLE, LOAD, EVAL, ISSUE, WAIT, ADV, FIN.
- IDLE: when `start`=1, capture `str`, `len` (clamped to `MAX_CHARS`), `x0` and `y0` into internal registers, then go to LOAD. Later input changes have no effect until the next start.
- LOAD: set idx=0, cursor=(x0,y0) and col=0, then go to EVAL.
- EVAL:
  - If idx==len, go to FIN.
  - If the code is 0x00 or 0x20, go to ADV without issuing a request.
  - If the code is 0x0A and `TEXT_WRAP_EN` is defined, do a newline: cursor_x=x0, cursor_y+=`GLYPH_H`+`GAP_Y`, col=0, idx+1, then return to EVAL.
  - Otherwise go to ISSUE.
- ISSUE: drive `char_valid`=1 with `char_code`/`char_x`/`char_y` held stable. Advance to WAIT on the cycle `char_valid`&`char_ready`.
- WAIT: hold outputs and `char_valid`=0. Go to ADV on `char_done`. A `char_done` in any other state is ignored.
- ADV: idx+1, col+1, cursor_x+=`GLYPH_W`+`GAP_X`. If `TEXT_WRAP_EN` is defined and col+1==`LINE_CHARS`, do the newline instead. Then go to EVAL.
- FIN: pulse `done` and go to IDLE.
- `start` while busy is ignored.
- Coordinate arithmetic is unsigned, modulo 2^`COORD_W`; there is no clipping. Out-of-screen coordinates are the plotter's concern.

## Timing
- Reset values: state=IDLE; `char_valid`, `busy` and `done` = 0; `char_code`, `char_x` and `char_y` = 0.
- `reset` mid-string goes immediately to IDLE. No `done` is produced and any outstanding plotter request is abandoned.
- `busy` rises the cycle after `start` is sampled.
- The first `char_valid` appears 3 cycles after the `start` cycle (IDLE→LOAD→EVAL→ISSUE).
- Per-glyph overhead beyond the plotter is 3 cycles (ISSUE handshake, ADV, EVAL). A skipped blank costs 2 cycles.
- `len`=0: `done` is asserted 3 cycles after `start` and no `char_valid` occurs.
- `char_ready` and `char_done` in the same cycle while in ISSUE: the handshake completes, `done` is not consumed, and WAIT waits for the next `char_done`.
- `done` and `busy` are both high in FIN. `busy` falls with `done`.

## Configuration
- `TEXT_WRAP_EN` defined: wrap after `LINE_CHARS` glyph cells, and 0x0A acts as a newline.
- `TEXT_WRAP_EN` undefined:
  - The whole string goes on one line and col is unused.
  - 0x0A is treated like a blank: it is skipped and the cursor advances.

## Structure
- Package `text_pkg`:
  - state enum `text_state_e`;
  - constants `ASCII_NUL`, `ASCII_SPACE`, `ASCII_LF`;
  - default pitch constants shared with the plotter.
- One sub-module, `text_cursor`: holds cursor_x, cursor_y and col, with inputs load/advance/newline, parametrised by pitch and `LINE_CHARS`.

## Test plan
- "HI", len=2, origin (100,50), plotter ready always, done 4 cycles after accept → requests (0x48,100,50) then (0x49,115,50), then one `done` pulse.
- "A B", len=3 → two requests at x=0 and x=30 with no request for the space; the cycle gap matches the 2-cycle skip.
- `TEXT_WRAP_EN`, `LINE_CHARS`=2, "ABC" at (0,0) → C drawn at (0,18). Without the macro, C is at (30,0).
- len=0, and separately len=20 with `MAX_CHARS`=16 → `done` at cycle 3 with no requests; the clamped case stops after 16 glyphs.
- `char_ready` held low for 10 cycles → `char_valid` and coordinates stay stable throughout, and a `start` pulse during this time is ignored.
- `reset` asserted in WAIT mid-string → all outputs are 0 asynchronously, no `done` is produced, and a fresh `start` renders from `str[0]`.
